// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and sequencing control for the 5-stage pipeline.
// It drives the enable, bubble and flush controls of the pipeline registers
// and the PC. It also produces the ID-stage forwarding selects and runs the
// data-memory handshake FSM, which includes a watchdog.
// Build option: define PIPE_HAZARD_FWD_EN to turn on operand forwarding.
// When the macro is undefined, every RAW hazard stalls instead.
module pipe_hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CW      = 5
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [4:0] drs,
    input  logic [4:0] drt,
    input  logic       duse_rs,
    input  logic       duse_rt,
    input  logic       dpcsrc,
    input  logic       ewreg,
    input  logic       em2reg,
    input  logic [4:0] ern,
    input  logic       mwreg,
    input  logic       mm2reg,
    input  logic [4:0] mrn,
    input  logic       mmem,
    input  logic       dmem_ack,
    input  logic       err_clr,
    output logic       pc_en,
    output logic       fd_en,
    output logic       de_en,
    output logic       em_en,
    output logic       mw_en,
    output logic       fd_flush,
    output logic       de_bubble,
    output logic       mw_bubble,
    output logic [1:0] fwda,
    output logic [1:0] fwdb,
    output logic       dmem_req,
    output logic       mem_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ERR  = 2'd2;

    logic [1:0]    state, state_nxt;
    logic [CW-1:0] count, count_nxt;
    logic          mem_err_nxt;
    logic          memstall, in_err, hz;

    // An EX-stage producer that writes a nonzero register equal to r.
    function automatic logic hit_ex(input logic [4:0] r);
        return ewreg && (ern != 5'd0) && (ern == r);
    endfunction

    // An M-stage producer that writes a nonzero register equal to r.
    function automatic logic hit_m(input logic [4:0] r);
        return mwreg && (mrn != 5'd0) && (mrn == r);
    endfunction

`ifdef PIPE_HAZARD_FWD_EN
    // Forwarding source for one operand. EX has priority over M. A load in EX
    // cannot forward yet, because that case is covered by the load-use stall.
    function automatic logic [1:0] fwd_sel(input logic [4:0] r);
        if (hit_ex(r) && !em2reg) return 2'd1;
        else if (hit_m(r))        return mm2reg ? 2'd3 : 2'd2;
        else                      return 2'd0;
    endfunction

    assign fwda = fwd_sel(drs);
    assign fwdb = fwd_sel(drt);
    // Only a load in EX feeding the ID instruction has to stall.
    assign hz = ewreg && em2reg && (ern != 5'd0) &&
                ((duse_rs && ern == drs) || (duse_rt && ern == drt));
`else
    logic unused_mm2reg;
    // mm2reg only selects between forwarding sources, so it has no role here.
    assign unused_mm2reg = mm2reg;
    assign fwda = 2'd0;
    assign fwdb = 2'd0;
    // Without forwarding, any pending write to an operand the ID instruction reads stalls it.
    assign hz = (duse_rs && (hit_ex(drs) || hit_m(drs))) ||
                (duse_rt && (hit_ex(drt) || hit_m(drt)));
`endif

    assign in_err   = (state == S_ERR);
    assign memstall = ((state == S_IDLE) && mmem && !dmem_ack) ||
                      ((state == S_WAIT) && !dmem_ack);
    assign dmem_req = (state == S_IDLE) ? mmem : (state == S_WAIT);

    // Pipeline control, in priority order: ERR, memory stall, hazard stall, branch flush.
    always_comb begin
        pc_en     = 1'b1;
        fd_en     = 1'b1;
        de_en     = 1'b1;
        em_en     = 1'b1;
        mw_en     = 1'b1;
        fd_flush  = 1'b0;
        de_bubble = 1'b0;
        mw_bubble = 1'b0;
        if (in_err) begin
            pc_en     = 1'b0;
            fd_en     = 1'b0;
            de_en     = 1'b0;
            em_en     = err_clr;
            mw_en     = err_clr;
            mw_bubble = 1'b1;
        end else if (memstall) begin
            pc_en     = 1'b0;
            fd_en     = 1'b0;
            de_en     = 1'b0;
            em_en     = 1'b0;
            mw_bubble = 1'b1;
        end else if (hz) begin
            pc_en     = 1'b0;
            fd_en     = 1'b0;
            de_bubble = 1'b1;
        end else begin
            fd_flush  = dpcsrc;
        end
    end

    // Memory handshake sequencing and watchdog.
    always_comb begin
        state_nxt   = state;
        count_nxt   = count;
        mem_err_nxt = mem_err;
        case (state)
            S_IDLE: begin
                if (mmem && !dmem_ack) begin
                    state_nxt = S_WAIT;
                    count_nxt = CW'(1);
                end
            end
            S_WAIT: begin
                if (dmem_ack) begin
                    state_nxt = S_IDLE;
                    count_nxt = '0;
                end else if (count == CW'(TIMEOUT - 1)) begin
                    state_nxt   = S_ERR;
                    count_nxt   = '0;
                    mem_err_nxt = 1'b1;
                end else begin
                    count_nxt = count + CW'(1);
                end
            end
            S_ERR: begin
                if (err_clr) begin
                    state_nxt   = S_IDLE;
                    mem_err_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                count_nxt = '0;
            end
        endcase
    end

    // State, watchdog count and sticky error flag.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= S_IDLE;
            count   <= '0;
            mem_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            count   <= count_nxt;
            mem_err <= mem_err_nxt;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl with TIMEOUT=16.
// Expectations follow whichever build variant PIPE_HAZARD_FWD_EN selects.
module tb_pipe_hazard_ctrl;

`ifdef PIPE_HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       resetn;
    logic [4:0] drs, drt, ern, mrn;
    logic       duse_rs, duse_rt, dpcsrc, ewreg, em2reg, mwreg, mm2reg;
    logic       mmem, dmem_ack, err_clr;
    logic       pc_en, fd_en, de_en, em_en, mw_en;
    logic       fd_flush, de_bubble, mw_bubble, dmem_req, mem_err;
    logic [1:0] fwda, fwdb;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_hazard_ctrl #(.TIMEOUT(16), .CW(5)) dut (
        .clock(clock), .resetn(resetn),
        .drs(drs), .drt(drt), .duse_rs(duse_rs), .duse_rt(duse_rt),
        .dpcsrc(dpcsrc), .ewreg(ewreg), .em2reg(em2reg), .ern(ern),
        .mwreg(mwreg), .mm2reg(mm2reg), .mrn(mrn), .mmem(mmem),
        .dmem_ack(dmem_ack), .err_clr(err_clr),
        .pc_en(pc_en), .fd_en(fd_en), .de_en(de_en), .em_en(em_en), .mw_en(mw_en),
        .fd_flush(fd_flush), .de_bubble(de_bubble), .mw_bubble(mw_bubble),
        .fwda(fwda), .fwdb(fwdb), .dmem_req(dmem_req), .mem_err(mem_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Enables packed as {pc,fd,de,em,mw}.
    function automatic logic [7:0] ens();
        return {3'b0, pc_en, fd_en, de_en, em_en, mw_en};
    endfunction

    // Flags packed as {fd_flush,de_bubble,mw_bubble,dmem_req,mem_err}.
    function automatic logic [7:0] flg();
        return {3'b0, fd_flush, de_bubble, mw_bubble, dmem_req, mem_err};
    endfunction

    function automatic logic [7:0] fwd();
        return {4'b0, fwda, fwdb};
    endfunction

    task automatic clear_inputs();
        drs = 0; drt = 0; ern = 0; mrn = 0;
        duse_rs = 0; duse_rt = 0; dpcsrc = 0; ewreg = 0; em2reg = 0;
        mwreg = 0; mm2reg = 0; mmem = 0; dmem_ack = 0; err_clr = 0;
    endtask

    // Go to the next negedge; drive inputs there and check 2 time units later.
    task automatic next();
        @(negedge clock);
    endtask

    initial begin
        clear_inputs();
        resetn = 1'b0;
        #12;
        chk("reset_ens", ens(), 8'h1F);
        chk("reset_flg", flg(), 8'h00);
        chk("reset_fwd", fwd(), 8'h00);
        next(); resetn = 1'b1;

        // EX ALU result feeds rs.
        next(); ewreg = 1; em2reg = 0; ern = 5; drs = 5; duse_rs = 1;
        #2;
        chk("fwd_ex", fwd(), FWD ? 8'h04 : 8'h00);
        chk("fwd_ex_ens", ens(), FWD ? 8'h1F : 8'h07);
        chk("fwd_ex_flg", flg(), FWD ? 8'h00 : 8'h08);
        // EX has priority over an M-stage load to the same register.
        mwreg = 1; mrn = 5; mm2reg = 1;
        #1;
        chk("fwd_ex_pri", fwd(), FWD ? 8'h04 : 8'h00);
        // M load data, then M ALU result.
        ewreg = 0;
        #1;
        chk("fwd_m_mem", fwd(), FWD ? 8'h0C : 8'h00);
        mm2reg = 0;
        #1;
        chk("fwd_m_alu", fwd(), FWD ? 8'h08 : 8'h00);
        // Register 0 is never forwarded and never causes a stall.
        ewreg = 1; ern = 0; drs = 0; mrn = 0;
        #1;
        chk("fwd_r0", fwd(), 8'h00);
        chk("fwd_r0_ens", ens(), 8'h1F);
        // rt path: M ALU result on register 9.
        drs = 1; duse_rs = 0; drt = 9; duse_rt = 1; mrn = 9; ewreg = 0;
        #1;
        chk("fwdb_m_alu", fwd(), FWD ? 8'h02 : 8'h00);
        chk("fwdb_ens", ens(), FWD ? 8'h1F : 8'h07);

        // Load-use stall with a branch in the same cycle: the stall wins.
        next(); clear_inputs();
        ewreg = 1; em2reg = 1; ern = 7; drt = 7; duse_rt = 1; dpcsrc = 1;
        #2;
        chk("lu_ens", ens(), 8'h07);
        chk("lu_flg", flg(), 8'h08);
        // Once the load moves on, the branch flushes.
        next(); ewreg = 0; em2reg = 0;
        #2;
        chk("flush_ens", ens(), 8'h1F);
        chk("flush_flg", flg(), 8'h10);

        // Zero-wait access: the request goes out with no stall.
        next(); clear_inputs(); mmem = 1; dmem_ack = 1;
        #2;
        chk("zw_ens", ens(), 8'h1F);
        chk("zw_flg", flg(), 8'h02);

        // Ack 3 cycles after the request. Load-use and branch are masked while stalled.
        next(); clear_inputs(); mmem = 1;
        ewreg = 1; em2reg = 1; ern = 7; drt = 7; duse_rt = 1; dpcsrc = 1;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk($sformatf("ms_ens%0d", i), ens(), 8'h01);
            chk($sformatf("ms_flg%0d", i), flg(), 8'h06);
            next();
        end
        clear_inputs(); dmem_ack = 1;
        #2;
        chk("ms_ack_ens", ens(), 8'h1F);
        chk("ms_ack_flg", flg(), 8'h02);
        next(); clear_inputs();
        #2;
        chk("ms_idle_flg", flg(), 8'h00);

        // Watchdog: no ack, error after 16 cycles.
        next(); mmem = 1;
        for (int i = 0; i < 16; i++) begin
            #2;
            chk($sformatf("wd_wait%0d", i), flg(), 8'h06);
            next();
        end
        #2;
        chk("err_ens", ens(), 8'h00);
        chk("err_flg", flg(), 8'h05);
        // An ack in ERR is ignored.
        next(); mmem = 0; dmem_ack = 1;
        #2;
        chk("err_ack_ign", flg(), 8'h05);
        // err_clr squashes the stalled M instruction.
        next(); dmem_ack = 0; err_clr = 1;
        #2;
        chk("clr_ens", ens(), 8'h03);
        chk("clr_flg", flg(), 8'h05);
        next(); err_clr = 0;
        #2;
        chk("clr_after_ens", ens(), 8'h1F);
        chk("clr_after_flg", flg(), 8'h00);

        // Async reset in the middle of WAIT.
        next(); mmem = 1;
        next(); mmem = 0;
        #2;
        chk("wait_req", flg(), 8'h06);
        resetn = 1'b0;
        #1;
        chk("rst_wait_ens", ens(), 8'h1F);
        chk("rst_wait_flg", flg(), 8'h00);
        next(); resetn = 1'b1;

        // Async reset while in ERR clears the sticky flag.
        next(); mmem = 1;
        repeat (16) next();
        mmem = 0;
        #2;
        chk("err2_flg", flg(), 8'h05);
        resetn = 1'b0;
        #1;
        chk("rst_err_flg", flg(), 8'h00);
        chk("rst_err_ens", ens(), 8'h1F);
        next(); resetn = 1'b1;

        // Stall on an M-stage producer without forwarding; a plain forward with it.
        next(); clear_inputs(); mwreg = 1; mrn = 3; drs = 3; duse_rs = 1;
        #2;
        chk("m_raw_ens", ens(), FWD ? 8'h1F : 8'h07);
        chk("m_raw_flg", flg(), FWD ? 8'h00 : 8'h08);
        chk("m_raw_fwd", fwd(), FWD ? 8'h08 : 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencer for the 5-stage pipelined CPU. Drives the enable, bubble and flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC.
- Generates the operand-forwarding selects for the ID stage.
- Runs a handshake FSM with the data memory for multi-cycle accesses, with a watchdog timeout.

Parameters:
- TIMEOUT, 16, max cycles waiting for dmem_ack before declaring a memory error (>=2).
- CW, 5, watchdog counter width; 2^CW must be >= TIMEOUT.

Ports:
- clock  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- drs, drt  in  5 each  ID-stage source register numbers
- duse_rs, duse_rt  in  1 each  ID instruction reads rs / rt
- dpcsrc  in  1  ID-stage branch/jump taken
- ewreg, em2reg  in  1 each  EX-stage writes reg / is load
- ern  in  5  EX-stage destination register
- mwreg, mm2reg  in  1 each  M-stage writes reg / is load
- mrn  in  5  M-stage destination register
- mmem  in  1  M-stage instruction is a load or store
- dmem_ack  in  1  data memory completes access this cycle
- err_clr  in  1  clears the error halt
- pc_en, fd_en, de_en, em_en, mw_en  out  1 each  register write enables
- fd_flush  out  1  IF/ID loads a NOP
- de_bubble  out  1  ID/EX loads zero controls
- mw_bubble  out  1  MEM/WB loads wwreg=0, wm2reg=0
- fwda, fwdb  out  2 each  0=regfile, 1=EX alu, 2=M alu, 3=M mem data
- dmem_req  out  1  memory access request
- mem_err  out  1  sticky timeout flag

Behaviour:
- Reset (async, resetn low):
  - State IDLE, watchdog count 0, mem_err 0.
  - Resulting outputs with all inputs 0: all *_en 1; fd_flush, de_bubble, mw_bubble, dmem_req 0; fwda/fwdb 0.
- Forwarding (combinational), shown for fwda; fwdb is identical using drt/duse_rt:
  - If ewreg & ern!=0 & ern==drs & ~em2reg: fwda=1.
  - Else if mwreg & mrn!=0 & mrn==drs: fwda = mm2reg ? 3 : 2.
  - Else fwda=0.
  - Register 0 is never forwarded. EX has priority over M.
- Load-use stall (lu):
  - lu = ewreg & em2reg & ern!=0 & ((duse_rs & ern==drs) | (duse_rt & ern==drt)).
  - Effect: pc_en=0, fd_en=0, de_bubble=1; em_en and mw_en stay 1.
- Branch flush: fd_flush = dpcsrc & ~lu & ~memstall.
  - When a stall coincides with a branch, the stall wins; the branch re-evaluates next cycle.
- Memory FSM states:
  - IDLE:
    - dmem_req = mmem.
    - mmem & dmem_ack: zero-wait access, no stall, stay IDLE.
    - mmem & ~dmem_ack: memstall=1, go to WAIT, count=1.
  - WAIT:
    - dmem_req=1, memstall = ~dmem_ack.
    - On dmem_ack: memstall=0 this cycle, go to IDLE, count=0.
    - Else if count==TIMEOUT-1: go to ERR, set mem_err. Else count+1.
  - ERR:
    - dmem_req=0, all *_en=0, mw_bubble=1 (pipeline halted).
    - err_clr: mem_err=0, go to IDLE, and the stalled M instruction is squashed that cycle (mw_en=1, mw_bubble=1, em_en=1).
    - dmem_ack is ignored in ERR.
- memstall effect: pc_en=fd_en=de_en=em_en=0, mw_en=1, mw_bubble=1 (no duplicate writeback). lu and fd_flush are masked while memstall or ERR.
- Priority: ERR > memstall > lu > flush.
- Reset mid-WAIT returns to IDLE immediately and drops dmem_req.

Optional Feature:
- Macro: PIPE_HAZARD_FWD_EN.
- Defined: forwarding as above; only load-use hazards stall.
- Undefined:
  - fwda=fwdb=0 constant.
  - Stall (same effect as lu) on any RAW hazard against EX or M: (ewreg & ern!=0 & match) | (mwreg & mrn!=0 & match), where match uses duse_rs/duse_rt.

Test Plan:
- Reset, then ewreg=1, em2reg=0, ern=5, drs=5 -> fwda=1; also mwreg=1, mrn=5, mm2reg=1 -> fwda still 1; ern=0 and drs=0 -> fwda=0.
- ewreg=1, em2reg=1, ern=7, drt=7, duse_rt=1, dpcsrc=1 -> pc_en=0, fd_en=0, de_bubble=1, fd_flush=0 for exactly that cycle.
- mmem=1, dmem_ack arrives 3 cycles later -> dmem_req high 4 cycles; pc/fd/de/em enables 0 and mw_bubble=1 for 3 cycles; state returns to IDLE.
- mmem=1, no ack, TIMEOUT=16 -> mem_err rises after 16 cycles, all *_en=0; pulse err_clr -> mem_err=0 next cycle, IDLE, M instruction squashed.
- resetn asserted low during WAIT -> dmem_req=0 and mem_err=0 asynchronously; enables return to 1.
- Macro undefined: mwreg=1, mrn=3, drs=3, duse_rs=1 -> pc_en=0, de_bubble=1, fwda=0.
